mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the multi-cycle CPU datapath. It consumes the latched A/B operand register outputs at the start of a MULT/MULTU/DIV/DIVU instruction, computes over 32 iterations, and writes the HI/LO special registers. It gives the control FSM a start/busy/done handshake so the FSM can stall until HI/LO are valid. MTHI/MTLO writes also land here.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  begin operation using a, b, op; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  32  operand A (rs), from ALU operand register
- b  input  32  operand B (rt), from ALU operand register
- hi_we  input  1  MTHI: load wdata into HI (IDLE only)
- lo_we  input  1  MTLO: load wdata into LO (IDLE only)
- wdata  input  32  data for MTHI/MTLO
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- hi  output  32  HI register (mult upper word / remainder)
- lo  output  32  LO register (mult lower word / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if start=1, capture |a|, |b| (absolute value for MULT/DIV; raw for MULTU/DIVU), op, sign flags a[31], b[31]; clear 64-bit accumulator and iteration counter; go to CALC. Otherwise apply hi_we/lo_we (both may be set together).
- start and hi_we/lo_we in the same IDLE cycle: start wins, writes dropped.
- CALC: exactly 32 iterations, one per cycle, counter 0..31.
  - Multiply: shift-add, LSB-first over multiplier; 64-bit unsigned product of magnitudes.
  - Divide: restoring, MSB-first; 33-bit partial remainder subtract, quotient bit shifted in.
  - After iteration 31, go to FIX.
- FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
  - MULT: negate 64-bit product (two's complement) if a[31]^b[31].
  - DIV: negate quotient if a[31]^b[31]; remainder takes sign of a.
  - Divide by zero (b=0), DIV or DIVU: LO=32'hFFFFFFFF, HI=a (original, unmodified).
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0 (natural two's-complement wrap).
- start, hi_we, lo_we ignored in CALC and FIX. HI/LO hold their old values until FIX.
- a/b may change after the start cycle; only the captured values are used.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Takes effect without a clock edge. Any in-flight operation is abandoned with no HI/LO write.
- Edge E0 (start=1 in IDLE): busy=1 from E0 onward.
- Edges E1..E32: iterations 0..31.
- Edge E33 (FIX): hi/lo updated, done=1, busy=0.
- Both outputs valid in the cycle after E33; done returns to 0 at E34.
- Total: busy high 33 cycles. A new start is accepted at E34, earliest the cycle after done.
- MTHI/MTLO: hi/lo updated at the edge where hi_we/lo_we are sampled in IDLE; no done pulse.
- busy, done, hi, lo are all registered outputs; no combinational path from inputs.

## Test plan
- MULT a=7, b=32'hFFFFFFFD (−3) -> after E33: hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse 1 cycle, busy high 33 cycles.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. MULT on the same operands -> hi=0, lo=1.
- DIV a=32'hFFFFFFF9 (−7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=32'h12345678, b=0 -> lo=32'hFFFFFFFF, hi=32'h12345678. DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Start MULT, then pulse start and hi_we at cycle 10 -> both ignored, result correct at E33. MTLO wdata=32'hA5A5A5A5 in IDLE -> lo updated next edge, no done.
- Assert reset asynchronously at iteration 15 (mid-edge) -> busy, done, hi, lo immediately 0. After release, a fresh DIVU 9/3 -> lo=3, hi=0 at E33.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Operations take 33 busy cycles: 32 shift-add / restoring-divide steps, then a sign fix-up.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        neg_a;
  logic        neg_b;
  logic [4:0]  cnt;
  logic [63:0] acc;  // product, or {remainder, quotient}
  logic [63:0] sh;   // shifted multiplicand, or dividend shifting out MSB-first
  logic [31:0] opb;  // multiplier (shifts right) or divisor (static)

  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        is_div;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op_signed = ~op[0];
  assign abs_a     = (op_signed && a[31]) ? 32'd0 - a : a;
  assign abs_b     = (op_signed && b[31]) ? 32'd0 - b : b;
  assign is_div    = op_q[1];

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    div_shift = {acc[63:32], sh[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ge    = ~div_diff[33];
    if (is_div)
      acc_next = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
    else
      acc_next = acc + (opb[0] ? sh : 64'd0);

    prod_fix = (neg_a ^ neg_b) ? 64'd0 - acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? 32'd0 - acc[31:0] : acc[31:0];
    rem_fix  = neg_a ? 32'd0 - acc[63:32] : acc[63:32];
    // With a zero divisor every step subtracts nothing, so the remainder is already a.
    if (opb == 32'd0)
      quo_fix = 32'hFFFF_FFFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 2'b00;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      cnt   <= 5'd0;
      acc   <= 64'd0;
      sh    <= 64'd0;
      opb   <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_a <= op_signed & a[31];
            neg_b <= op_signed & b[31];
            sh    <= {32'd0, abs_a};
            opb   <= abs_b;
            acc   <= 64'd0;
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_next;
          sh  <= sh << 1;
          if (!is_div) opb <= opb >> 1;
          if (cnt == 5'd31) state <= FIX;
          else              cnt   <= cnt + 5'd1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          cnt   <= 5'd0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
